// File: rtl/da_tlc5620_pkg.sv
// Shared FSM state encoding and frame constants for the TLC5620 serial driver.
package da_tlc5620_pkg;

    localparam int WORD_BITS   = 11;
    localparam int PHASE_TICKS = 2;

    typedef enum logic [2:0] {
        S_SHIFT = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_LDAC  = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

endpackage

// File: rtl/da_tlc5620_tick_gen.sv
// Divides clk into a one-cycle tick every CLK_DIV cycles and a free-running
// da_clk that toggles on every tick.
module da_tlc5620_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic da_clk
);

    // CLK_DIV of 1 still needs a one-bit counter so the compare stays legal.
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            da_clk  <= 1'b0;
        end else if (tick) begin
            cnt_reg <= '0;
            da_clk  <= ~da_clk;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/da_tlc5620.sv
// TLC5620 serial driver: shifts an internally generated ramp to the DAC as
// {A1,A0,RNG,D7..D0}, then strobes LOAD and LDAC; LED mirrors the DAC value.
module da_tlc5620
    import da_tlc5620_pkg::*;
#(
    parameter int         CLK_DIV = 25,
    parameter logic [1:0] CHANNEL = 2'b00,
    parameter logic       RNG     = 1'b1,
    parameter logic [7:0] STEP    = 8'd1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    output logic       DA_IO_CLK,
    output logic       DA_LOAD,
    output logic       DA_LDAC,
    output logic       DA_OUT_DATA,
    output logic [7:0] LED,
    output logic       da_clk
);

    localparam int IW = $clog2(WORD_BITS);
    localparam int PW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;

    logic                 tick;
    state_t               state_reg;
    logic [IW-1:0]        bit_idx_reg;
    logic [PW-1:0]        phase_reg;
    logic [WORD_BITS-1:0] word_reg;
    logic [7:0]           ramp_reg;
    logic [WORD_BITS-1:0] frame_word;
    logic                 phase_last;

    assign frame_word = {CHANNEL, RNG, ramp_reg};
    assign phase_last = (phase_reg == PW'(PHASE_TICKS - 1));

    da_tlc5620_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .tick   (tick),
        .da_clk (da_clk)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= S_SHIFT;
            bit_idx_reg <= IW'(WORD_BITS - 1);
            phase_reg   <= '0;
            word_reg    <= '0;
            ramp_reg    <= '0;
            DA_IO_CLK   <= 1'b0;
            DA_LOAD     <= 1'b1;
            DA_LDAC     <= 1'b1;
            DA_OUT_DATA <= 1'b0;
            LED         <= 8'h00;
        end else if (tick) begin
            phase_reg <= phase_last ? '0 : phase_reg + 1'b1;
            case (state_reg)
                S_SHIFT: begin
                    if (!phase_last) begin
                        DA_IO_CLK <= 1'b1;
                        // The word is captured as its MSB goes out so the whole frame is coherent.
                        if (bit_idx_reg == IW'(WORD_BITS - 1)) begin
                            word_reg    <= frame_word;
                            DA_OUT_DATA <= frame_word[WORD_BITS-1];
                        end else begin
                            DA_OUT_DATA <= word_reg[bit_idx_reg];
                        end
                    end else begin
                        DA_IO_CLK <= 1'b0;
                        if (bit_idx_reg == '0) begin
                            state_reg <= S_LOAD;
                        end else begin
                            bit_idx_reg <= bit_idx_reg - 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    DA_LOAD     <= 1'b0;
                    DA_IO_CLK   <= 1'b0;
                    DA_OUT_DATA <= 1'b0;
                    if (phase_last) state_reg <= S_GAP;
                end
                S_GAP: begin
                    DA_LOAD <= 1'b1;
                    if (phase_last) state_reg <= S_LDAC;
                end
                S_LDAC: begin
                    DA_LDAC <= 1'b0;
                    if (!phase_last) LED <= word_reg[7:0];
                    if (phase_last) state_reg <= S_IDLE;
                end
                S_IDLE: begin
                    DA_LDAC <= 1'b1;
                    if (phase_last) begin
                        ramp_reg    <= ramp_reg + STEP;
                        bit_idx_reg <= IW'(WORD_BITS - 1);
                        state_reg   <= S_SHIFT;
                    end
                end
                default: begin
                    state_reg   <= S_SHIFT;
                    bit_idx_reg <= IW'(WORD_BITS - 1);
                    phase_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_tlc5620.sv
// Directed bench for da_tlc5620: decodes the serial pins of three differently
// parameterised instances and checks words, strobes, LED and clock timing.
module tb_da_tlc5620;

    localparam int NI   = 3;
    localparam int MEMD = 512;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       rst_n   [NI];
    logic       io_clk  [NI];
    logic       load_n  [NI];
    logic       ldac_n  [NI];
    logic       dout    [NI];
    logic       daclk   [NI];
    logic [7:0] led     [NI];

    da_tlc5620 #(.CLK_DIV(1), .CHANNEL(2'b00), .RNG(1'b1), .STEP(8'd1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(rst_n[0]), .DA_IO_CLK(io_clk[0]),
        .DA_LOAD(load_n[0]), .DA_LDAC(ldac_n[0]), .DA_OUT_DATA(dout[0]),
        .LED(led[0]), .da_clk(daclk[0])
    );

    da_tlc5620 #(.CLK_DIV(25), .CHANNEL(2'b00), .RNG(1'b1), .STEP(8'd1)) dut25 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n[1]), .DA_IO_CLK(io_clk[1]),
        .DA_LOAD(load_n[1]), .DA_LDAC(ldac_n[1]), .DA_OUT_DATA(dout[1]),
        .LED(led[1]), .da_clk(daclk[1])
    );

    da_tlc5620 #(.CLK_DIV(2), .CHANNEL(2'b10), .RNG(1'b0), .STEP(8'd3)) dut_p (
        .sys_clk(sys_clk), .sys_rst_n(rst_n[2]), .DA_IO_CLK(io_clk[2]),
        .DA_LOAD(load_n[2]), .DA_LDAC(ldac_n[2]), .DA_OUT_DATA(dout[2]),
        .LED(led[2]), .da_clk(daclk[2])
    );

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [10:0] shreg     [NI];
    int          nbits     [NI];
    int          wcnt      [NI] = '{default: 0};
    int          fcnt      [NI] = '{default: 0};
    int          load_run  [NI];
    int          ldac_run  [NI];
    int          load_len  [NI] = '{default: 0};
    int          ldac_len  [NI] = '{default: 0};
    int          overlap   [NI] = '{default: 0};
    int          dclk_bad  [NI] = '{default: 0};
    int          last_tog  [NI] = '{default: 0};
    logic        tog_valid [NI];
    logic        prev_io   [NI];
    logic        prev_load [NI];
    logic        prev_ldac [NI];
    logic        prev_dclk [NI];
    logic [10:0] word_mem  [NI][MEMD];
    int          nb_mem    [NI][MEMD];
    logic [7:0]  led_mem   [NI][MEMD];
    int          fall_cyc  [NI][MEMD];

    function automatic int div_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 25 : 2;
    endfunction

    // Pin decoder: bits are taken on DA_IO_CLK falling edges, a word is closed by LOAD falling.
    always @(negedge sys_clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
                shreg[i]     <= '0;
                nbits[i]     <= 0;
                load_run[i]  <= 0;
                ldac_run[i]  <= 0;
                prev_io[i]   <= 1'b0;
                prev_load[i] <= 1'b1;
                prev_ldac[i] <= 1'b1;
                prev_dclk[i] <= 1'b0;
                tog_valid[i] <= 1'b0;
            end else begin
                prev_io[i]   <= io_clk[i];
                prev_load[i] <= load_n[i];
                prev_ldac[i] <= ldac_n[i];
                prev_dclk[i] <= daclk[i];
                if (prev_io[i] && !io_clk[i]) begin
                    shreg[i] <= {shreg[i][9:0], dout[i]};
                    nbits[i] <= nbits[i] + 1;
                end
                if (prev_load[i] && !load_n[i]) begin
                    if (wcnt[i] < MEMD) begin
                        word_mem[i][wcnt[i]] <= shreg[i];
                        nb_mem[i][wcnt[i]]   <= nbits[i];
                    end
                    wcnt[i]     <= wcnt[i] + 1;
                    nbits[i]    <= 0;
                    load_run[i] <= 1;
                end else if (!load_n[i]) begin
                    load_run[i] <= load_run[i] + 1;
                end else if (!prev_load[i]) begin
                    load_len[i] <= load_run[i];
                end
                if (prev_ldac[i] && !ldac_n[i]) begin
                    if (fcnt[i] < MEMD) begin
                        led_mem[i][fcnt[i]]  <= led[i];
                        fall_cyc[i][fcnt[i]] <= cyc;
                    end
                    fcnt[i]     <= fcnt[i] + 1;
                    ldac_run[i] <= 1;
                end else if (!ldac_n[i]) begin
                    ldac_run[i] <= ldac_run[i] + 1;
                end else if (!prev_ldac[i]) begin
                    ldac_len[i] <= ldac_run[i];
                end
                if (!load_n[i] && !ldac_n[i]) overlap[i] <= overlap[i] + 1;
                if (prev_dclk[i] != daclk[i]) begin
                    if (tog_valid[i] && (cyc - last_tog[i]) != div_of(i))
                        dclk_bad[i] <= dclk_bad[i] + 1;
                    last_tog[i]  <= cyc;
                    tog_valid[i] <= 1'b1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_io_clk"}, int'(io_clk[0]), 0);
        check({tag, "_load"},   int'(load_n[0]), 1);
        check({tag, "_ldac"},   int'(ldac_n[0]), 1);
        check({tag, "_dout"},   int'(dout[0]),   0);
        check({tag, "_led"},    int'(led[0]),    0);
        check({tag, "_da_clk"}, int'(daclk[0]),  0);
    endtask

    initial begin
        int wbase;
        int fbase;
        int bad;
        logic [7:0] kb;

        rst_n = '{1'b0, 1'b0, 1'b0};
        step(5);
        check_reset_outputs("reset");
        $display("step reset: outputs sampled during reset");

        rst_n = '{1'b1, 1'b1, 1'b1};

        // First two frames at CLK_DIV=1
        for (int n = 0; n < 200 && fcnt[0] < 2; n++) step(1);
        step(5);
        check("f0_two_frames_seen", int'(fcnt[0] >= 2), 1);
        check("f0_word",  int'(word_mem[0][0]), 'h100);
        check("f0_nbits", nb_mem[0][0], 11);
        check("f0_led",   int'(led_mem[0][0]), 'h00);
        check("f1_word",  int'(word_mem[0][1]), 'h101);
        check("f1_nbits", nb_mem[0][1], 11);
        check("f1_led",   int'(led_mem[0][1]), 'h01);
        check("load_low_cycles", load_len[0], 2);
        check("ldac_low_cycles", ldac_len[0], 2);
        $display("step frames0/1: words 0x%0h 0x%0h", word_mem[0][0], word_mem[0][1]);

        // CHANNEL=2'b10, RNG=0, STEP=3, CLK_DIV=2
        for (int n = 0; n < 1000 && fcnt[2] < 3; n++) step(1);
        check("p_three_frames_seen", int'(fcnt[2] >= 3), 1);
        check("p_header", int'(word_mem[2][0][10:8]), 'b100);
        check("p_word0",  int'(word_mem[2][0]), 'h400);
        check("p_word1",  int'(word_mem[2][1]), 'h403);
        check("p_word2",  int'(word_mem[2][2]), 'h406);
        check("p_led1",   int'(led_mem[2][1]), 'h03);
        check("p_led2",   int'(led_mem[2][2]), 'h06);
        $display("step params: words 0x%0h 0x%0h 0x%0h", word_mem[2][0], word_mem[2][1], word_mem[2][2]);

        // Frame spacing at CLK_DIV=25
        for (int n = 0; n < 3000 && fcnt[1] < 2; n++) step(1);
        check("d25_two_frames_seen", int'(fcnt[1] >= 2), 1);
        check("d25_frame_spacing", fall_cyc[1][1] - fall_cyc[1][0], 750);
        check("d25_word0", int'(word_mem[1][0]), 'h100);
        $display("step div25: ldac spacing %0d cycles", fall_cyc[1][1] - fall_cyc[1][0]);

        // Ramp wrap-around
        for (int n = 0; n < 9000 && fcnt[0] < 258; n++) step(1);
        check("wrap_frames_seen", int'(fcnt[0] >= 258), 1);
        check("wrap_word255", int'(word_mem[0][255]), 'h1FF);
        check("wrap_word256", int'(word_mem[0][256]), 'h100);
        check("wrap_led255",  int'(led_mem[0][255]), 'hFF);
        check("wrap_led256",  int'(led_mem[0][256]), 'h00);
        bad = 0;
        for (int k = 0; k < 258; k++) begin
            kb = 8'(k);
            if (word_mem[0][k] !== {3'b001, kb} || nb_mem[0][k] != 11 || led_mem[0][k] !== kb)
                bad++;
        end
        check("ramp_sequence_bad_frames", bad, 0);
        $display("step wrap: frame255 0x%0h frame256 0x%0h", word_mem[0][255], word_mem[0][256]);

        // Reset in the middle of a SHIFT phase
        for (int n = 0; n < 100 && nbits[0] != 5; n++) step(1);
        check("mid_shift_reached", nbits[0], 5);
        rst_n[0] = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wbase = wcnt[0];
        fbase = fcnt[0];
        step(3);
        rst_n[0] = 1'b1;
        for (int n = 0; n < 100 && fcnt[0] <= fbase; n++) step(1);
        check("post_reset_frame_seen", int'(fcnt[0] > fbase), 1);
        check("post_reset_word",  int'(word_mem[0][wbase]), 'h100);
        check("post_reset_nbits", nb_mem[0][wbase], 11);
        check("post_reset_led",   int'(led_mem[0][fbase]), 'h00);
        $display("step midreset: restart word 0x%0h", word_mem[0][wbase]);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("strobe_overlap_%0d", i), overlap[i], 0);
            check($sformatf("da_clk_period_%0d", i), dclk_bad[i], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/da_tlc5620.md
Name: da_tlc5620

Overview:
Self-contained serial driver for a TI TLC5620 quad 8-bit DAC. It generates an 8-bit ramp value internally and shifts each value to the DAC as an 11-bit word (A1 A0 RNG D7..D0), then pulses LOAD and LDAC to update the analog output. The current DAC value is mirrored on LED. The block sits at board top level between the system clock/reset and the DAC pins.

Parameters:
CLK_DIV, 25, sys_clk cycles per tick (one half-period of the serial clock); must be ≥1
CHANNEL, 2'b00, DAC address bits A1:A0 sent in every word
RNG, 1'b1, range bit sent in every word (1 = x2 gain)
STEP, 8'd1, increment applied to the ramp value after each completed frame

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge
sys_rst_n  input  1  asynchronous active-low reset
DA_IO_CLK  output  1  DAC serial clock; the DAC samples data on its falling edge
DA_LOAD  output  1  DAC LOAD strobe, active low
DA_LDAC  output  1  DAC LDAC strobe, active low
DA_OUT_DATA  output  1  DAC serial data, MSB first
LED  output  8  value last transferred to the DAC output
da_clk  output  1  free-running divided clock; toggles on every tick (period 2*CLK_DIV sys_clk)

Behaviour:
- One clock domain (sys_clk). Asynchronous, active-low reset on sys_rst_n. All outputs are registered.
- Reset values: DA_IO_CLK=0, DA_LOAD=1, DA_LDAC=1, DA_OUT_DATA=0, LED=0, da_clk=0, ramp value=0, tick divider=0, FSM=SHIFT with bit index 10.
- Tick: the divider counts 0..CLK_DIV-1. A one-cycle tick is generated at count CLK_DIV-1, and the divider then wraps to 0. All FSM actions below happen only on tick cycles. da_clk toggles on every tick.
- Word: {CHANNEL, RNG, ramp[7:0]}, 11 bits, latched at frame start. Bit 10 (A1) is sent first.
- Frame of 30 ticks; the FSM holds each state for 2 ticks:
  - SHIFT, bits 10 down to 0:
    - First tick of a bit: DA_OUT_DATA is driven with the bit and DA_IO_CLK=1.
    - Second tick: DA_IO_CLK=0 (falling edge while the data is stable).
    - Total 22 ticks.
  - LOAD: DA_LOAD=0 for 2 ticks. DA_IO_CLK stays 0 and DA_OUT_DATA=0.
  - GAP: all strobes high for 2 ticks.
  - LDAC: DA_LDAC=0 for 2 ticks. LED is loaded with the frame's data value on the tick DA_LDAC falls.
  - IDLE: 2 ticks with all strobes high. On the final IDLE tick, ramp <= ramp + STEP (mod 256) and the FSM returns to SHIFT with bit index 10.
- DA_LOAD and DA_LDAC are never low at the same time. DA_IO_CLK is held low outside SHIFT.
- Wrap-around: ramp 8'hFF + 1 gives 8'h00 with no stall. The next frame sends data 0x00.
- Reset asserted mid-frame: all outputs return to their reset values immediately. After release, the frame restarts from bit 10 with data 0.
- The block has no external data input and no handshake. It sends frames continuously.

Decomposition:
- A shared package holds the FSM state enum (SHIFT, LOAD, GAP, LDAC, IDLE) and the constants WORD_BITS=11 and PHASE_TICKS=2.
- One sub-module is natural: tick_gen (parameter CLK_DIV), which outputs the tick pulse and da_clk.
- The FSM, shift register and ramp counter stay in da_tlc5620.

Test Plan:
- Reset: hold sys_rst_n=0 for 5 cycles -> DA_IO_CLK=0, DA_LOAD=1, DA_LDAC=1, DA_OUT_DATA=0, LED=8'h00, da_clk=0.
- First frame (CLK_DIV=1): sample DA_OUT_DATA on each DA_IO_CLK falling edge -> exactly 11 bits 0,0,1,0,0,0,0,0,0,0,0. Then DA_LOAD is low for 2 cycles, DA_LDAC is low for 2 cycles, and LED=8'h00.
- Second frame -> data bits decode to 8'h01 and LED becomes 8'h01 on DA_LDAC fall. Frame spacing is 30 ticks (30*CLK_DIV sys_clk); check with CLK_DIV=25 -> 750 cycles.
- Wrap: run 256 frames with CLK_DIV=1 -> frame 255 sends 8'hFF and frame 256 sends 8'h00; LED follows.
- Reset mid-SHIFT (assert at bit 5 of frame 3) -> outputs return to reset values at once. After release, the next frame sends data 8'h00 starting with A1.
- Parameters CHANNEL=2'b10, RNG=0, STEP=8'd3 -> header bits 1,0,0 and data sequence 00, 03, 06; da_clk period is 2*CLK_DIV cycles throughout.
